// File: rtl/debounced_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : debounced_updown_counter_if
// Description : Button/counter bundle between the board-side driver (master)
//               and the debounced up/down counter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface debounced_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             btn_up;
   logic             btn_dn;
   logic             clr;
   logic [WIDTH-1:0] cnt;
   logic             up_pulse;
   logic             dn_pulse;
   logic             limit;

   modport master (
      output btn_up, btn_dn, clr,
      input  cnt, up_pulse, dn_pulse, limit
   );

   modport slave (
      input  btn_up, btn_dn, clr,
      output cnt, up_pulse, dn_pulse, limit
   );
endinterface
`default_nettype wire

// File: rtl/debounced_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : debounced_updown_counter
// Description : Two raw buttons, each synchronised, debounced and edge
//               detected, drive a WIDTH-bit up/down counter with a
//               programmable terminal value, wrap/saturate mode and a
//               synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module debounced_updown_counter #(
   parameter int WIDTH      = 4,
   parameter int DEB_CYCLES = 16,
   parameter int MAX_VAL    = 9,
   parameter int SATURATE   = 0
) (
   input  logic                        clk,
   input  logic                        rst,   // asynchronous, active-low
   debounced_updown_counter_if.slave   bus
);

   localparam int               DC_W  = $clog2(DEB_CYCLES);
   localparam logic [DC_W-1:0]  c_DC_LAST = DC_W'(DEB_CYCLES - 1);
   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

   // Channel 0 = up, channel 1 = down
   logic [1:0] w_raw;
   logic [1:0] w_edge;

   assign w_raw = {bus.btn_dn, bus.btn_up};

   for (genvar i = 0; i < 2; i++) begin : g_chan
      logic            r_sync1;
      logic            r_sync2;
      logic            r_st;
      logic            r_st_d;
      logic [DC_W-1:0] r_dc;

      // Two-flop synchroniser for the asynchronous button level
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
         end else begin
            r_sync1 <= w_raw[i];
            r_sync2 <= r_sync1;
         end
      end

      // Accept a new level only after DEB_CYCLES consecutive differing samples
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_st <= 1'b0;
            r_dc <= '0;
         end else if (r_sync2 == r_st) begin
            r_dc <= '0;
         end else if (r_dc == c_DC_LAST) begin
            r_st <= r_sync2;
            r_dc <= '0;
         end else begin
            r_dc <= r_dc + DC_W'(1);
         end
      end

      // History of the stable level for rising-edge detection
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_st_d <= 1'b0;
         end else begin
            r_st_d <= r_st;
         end
      end

      // Press only: a falling stable level never generates a step
      assign w_edge[i] = r_st & ~r_st_d;
   end : g_chan

   logic             w_u;
   logic             w_d;
   logic [WIDTH-1:0] r_cnt;
   logic             r_up_pulse;
   logic             r_dn_pulse;
   logic             r_limit;

   assign w_u = w_edge[0];
   assign w_d = w_edge[1];

   // Step the counter; clear wins, simultaneous up+down cancels out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_up_pulse <= 1'b0;
         r_dn_pulse <= 1'b0;
         r_limit    <= 1'b0;
      end else begin
         r_up_pulse <= w_u;
         r_dn_pulse <= w_d;
         if (bus.clr) begin
            r_cnt   <= '0;
            r_limit <= 1'b0;
         end else if (w_u && w_d) begin
            r_limit <= 1'b0;
         end else if (w_u) begin
            if (r_cnt < c_MAX) begin
               r_cnt   <= r_cnt + c_ONE;
               r_limit <= 1'b0;
            end else begin
               r_limit <= 1'b1;
               if (SATURATE == 0) begin
                  r_cnt <= '0;
               end
            end
         end else if (w_d) begin
            if (r_cnt != '0) begin
               r_cnt   <= r_cnt - c_ONE;
               r_limit <= 1'b0;
            end else begin
               r_limit <= 1'b1;
               if (SATURATE == 0) begin
                  r_cnt <= c_MAX;
               end
            end
         end else begin
            r_limit <= 1'b0;
         end
      end
   end

   assign bus.cnt      = r_cnt;
   assign bus.up_pulse = r_up_pulse;
   assign bus.dn_pulse = r_dn_pulse;
   assign bus.limit    = r_limit;

endmodule
`default_nettype wire
